// File: rtl/output_compare_pkg.sv
// Shared definitions for the output-compare channel: default counter width,
// match-action encodings and the compare register reset constant.
package output_compare_pkg;

  // Default counter / compare register width
  localparam int OC_CNT_WIDTH = 16;

  // Action taken on o_oc_pin when the counter matches the compare value
  typedef enum logic [1:0] {
    OC_MODE_SET = 2'b00,
    OC_MODE_CLR = 2'b01,
    OC_MODE_TGL = 2'b10,
    OC_MODE_PLS = 2'b11
  } oc_mode_e;

  // Compare registers come out of reset at all-ones so that a freshly reset
  // channel does not fire until the counter has run the full range.
  localparam logic [OC_CNT_WIDTH-1:0] OC_CMP_RST = {OC_CNT_WIDTH{1'b1}};

endpackage

// File: rtl/output_compare_oc_pulse_timer.sv
// Pulse-length down-counter for the output-compare channel.
// A trigger (re)loads the timer and raises active; active stays high for
// PULSE_LEN cycles. expired marks the last active cycle so the owner can drop
// its pin on the following edge. abort zeroes the timer immediately.
module oc_pulse_timer #(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic abort,
  output logic active,
  output logic expired
);

  // Timer loads with PULSE_LEN-1: the load cycle itself is the first high cycle
  localparam logic [7:0] LOAD_VAL = 8'(PULSE_LEN - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;
  logic       active_reg;
  logic       active_next;

  // Next-state: abort beats trigger, trigger beats countdown (retrigger reloads)
  always_comb begin
    count_next  = count_reg;
    active_next = active_reg;
    if (abort) begin
      count_next  = 8'd0;
      active_next = 1'b0;
    end else if (trigger) begin
      count_next  = LOAD_VAL;
      active_next = 1'b1;
    end else if (active_reg) begin
      if (count_reg == 8'd0) begin
        active_next = 1'b0;
      end else begin
        count_next = count_reg - 8'd1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= 8'd0;
      active_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      active_reg <= active_next;
    end
  end

  assign active  = active_reg;
  assign expired = active_reg && (count_reg == 8'd0);

endmodule

// File: rtl/output_compare.sv
// Output-compare channel: free-running counter, compare register, match
// detect, pin action (set/clear/toggle/pulse) and sticky match/wrap flags.
// Optional build macro OC_PRELOAD_EN: compare writes go to a shadow register
// that is copied to the active compare on a counter wrap or on i_clr.
module output_compare
  import output_compare_pkg::*;
#(
  parameter int CNT_WIDTH = OC_CNT_WIDTH,
  parameter int PULSE_LEN = 4
) (
  input  logic                 i_sysclk,
  input  logic                 i_sysrst,
  input  logic                 i_cnt_en,
  input  logic                 i_clr,
  input  logic                 i_cmp_we,
  input  logic [CNT_WIDTH-1:0] i_cmp_data,
  input  logic [1:0]           i_mode,
  input  logic                 i_flg_clr,
  output logic                 o_oc_pin,
  output logic                 o_oc_flg,
  output logic                 o_ovf_flg,
  output logic [CNT_WIDTH-1:0] o_cnt_data
);

  localparam logic [CNT_WIDTH-1:0] CMP_RST  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] cmp_active_reg;
  logic [CNT_WIDTH-1:0] cmp_active_next;
  logic                 pin_reg;
  logic                 pin_next;
  logic                 oc_flg_reg;
  logic                 oc_flg_next;
  logic                 ovf_flg_reg;
  logic                 ovf_flg_next;

  oc_mode_e mode;
  logic     match;
  logic     wrap;
  logic     pls_trigger;
  logic     pls_abort;
  logic     pls_active;
  logic     pls_expired;

  assign mode = oc_mode_e'(i_mode);

  // A match needs the counter to be running, so a counter parked on the
  // compare value produces one event per visit, not one per cycle.
  assign match = i_cnt_en && (cnt_reg == cmp_active_reg);

  // A wrap is only a natural increment past the top; i_clr is not a wrap.
  assign wrap = i_cnt_en && !i_clr && (cnt_reg == CNT_MAX);

  // Counter: clear has priority over enable
  always_comb begin
    cnt_next = cnt_reg;
    if (i_clr) begin
      cnt_next = CNT_ZERO;
    end else if (i_cnt_en) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

`ifdef OC_PRELOAD_EN
  logic [CNT_WIDTH-1:0] cmp_shadow_reg;
  logic [CNT_WIDTH-1:0] cmp_shadow_next;

  // Shadow compare: writes land here; the active compare picks up the
  // pre-write shadow on a wrap or clear so a period change never glitches.
  always_comb begin
    cmp_shadow_next = cmp_shadow_reg;
    cmp_active_next = cmp_active_reg;
    if (i_cmp_we) begin
      cmp_shadow_next = i_cmp_data;
    end
    if (wrap || i_clr) begin
      cmp_active_next = cmp_shadow_reg;
    end
  end

  // Shadow register
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      cmp_shadow_reg <= CMP_RST;
    end else begin
      cmp_shadow_reg <= cmp_shadow_next;
    end
  end
`else
  // Direct compare write: a match this cycle still sees the old value
  always_comb begin
    cmp_active_next = cmp_active_reg;
    if (i_cmp_we) begin
      cmp_active_next = i_cmp_data;
    end
  end
`endif

  // Pin action on match; in pulse mode the timer expiry drops the pin
  always_comb begin
    pin_next    = pin_reg;
    pls_trigger = 1'b0;
    pls_abort   = 1'b0;
    case (mode)
      OC_MODE_SET: begin
        pls_abort = 1'b1;
        if (match) pin_next = 1'b1;
      end
      OC_MODE_CLR: begin
        pls_abort = 1'b1;
        if (match) pin_next = 1'b0;
      end
      OC_MODE_TGL: begin
        pls_abort = 1'b1;
        if (match) pin_next = ~pin_reg;
      end
      OC_MODE_PLS: begin
        if (match) begin
          pin_next    = 1'b1;
          pls_trigger = 1'b1;
        end else if (pls_expired) begin
          pin_next = 1'b0;
        end
      end
      default: begin
        pls_abort = 1'b1;
      end
    endcase
  end

  // Sticky flags: a new set event wins over a same-cycle clear request
  always_comb begin
    oc_flg_next  = oc_flg_reg;
    ovf_flg_next = ovf_flg_reg;
    if (match) begin
      oc_flg_next = 1'b1;
    end else if (i_flg_clr) begin
      oc_flg_next = 1'b0;
    end
    if (wrap) begin
      ovf_flg_next = 1'b1;
    end else if (i_flg_clr) begin
      ovf_flg_next = 1'b0;
    end
  end

  // Main state registers with synchronous reset
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      cnt_reg        <= CNT_ZERO;
      cmp_active_reg <= CMP_RST;
      pin_reg        <= 1'b0;
      oc_flg_reg     <= 1'b0;
      ovf_flg_reg    <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      cmp_active_reg <= cmp_active_next;
      pin_reg        <= pin_next;
      oc_flg_reg     <= oc_flg_next;
      ovf_flg_reg    <= ovf_flg_next;
    end
  end

  oc_pulse_timer #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse_timer (
    .clk     (i_sysclk),
    .reset   (i_sysrst),
    .trigger (pls_trigger),
    .abort   (pls_abort),
    .active  (pls_active),
    .expired (pls_expired)
  );

  // pls_active is kept for observability; the pin path only needs expiry
  logic unused_ok;
  assign unused_ok = pls_active;

  assign o_oc_pin   = pin_reg;
  assign o_oc_flg   = oc_flg_reg;
  assign o_ovf_flg  = ovf_flg_reg;
  assign o_cnt_data = cnt_reg;

endmodule

// File: tb/tb_output_compare.sv
// Self-checking bench for output_compare. A cycle model computes the
// expected outputs as each cycle's stimulus is driven; the expectation is
// queued and compared after the edge. Directed checks with fixed expected
// values cover the scenarios of interest. Honours OC_PRELOAD_EN.
module tb_output_compare;
  import output_compare_pkg::*;

  localparam int CW = 16;
  localparam int PL = 4;

`ifdef OC_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          srst;
  logic          cnt_en;
  logic          clr;
  logic          cmp_we;
  logic [CW-1:0] cmp_data;
  logic [1:0]    mode;
  logic          flg_clr;
  logic          oc_pin;
  logic          oc_flg;
  logic          ovf_flg;
  logic [CW-1:0] cnt_data;

  always #5 clk = ~clk;

  output_compare #(
    .CNT_WIDTH (CW),
    .PULSE_LEN (PL)
  ) dut (
    .i_sysclk   (clk),
    .i_sysrst   (srst),
    .i_cnt_en   (cnt_en),
    .i_clr      (clr),
    .i_cmp_we   (cmp_we),
    .i_cmp_data (cmp_data),
    .i_mode     (mode),
    .i_flg_clr  (flg_clr),
    .o_oc_pin   (oc_pin),
    .o_oc_flg   (oc_flg),
    .o_ovf_flg  (ovf_flg),
    .o_cnt_data (cnt_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          pin;
    logic          flg;
    logic          ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_on = 1'b1;

  // Reference model state
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_cmp;
  logic [CW-1:0] m_shd;
  logic          m_pin;
  logic          m_flg;
  logic          m_ovf;
  int            m_left;   // pulse cycles still to be driven high after this one

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic match;
    logic wrap;
    if (srst) begin
      m_cnt = '0; m_cmp = '1; m_shd = '1;
      m_pin = 1'b0; m_flg = 1'b0; m_ovf = 1'b0; m_left = 0;
      return;
    end
    match = cnt_en && (m_cnt == m_cmp);
    wrap  = cnt_en && !clr && (m_cnt == {CW{1'b1}});
    if (PRELOAD) begin
      if (clr || wrap) m_cmp = m_shd;
      if (cmp_we) m_shd = cmp_data;
    end else begin
      if (cmp_we) m_cmp = cmp_data;
    end
    if (mode != OC_MODE_PLS) begin
      m_left = 0;
      if (match) begin
        if (mode == OC_MODE_SET) m_pin = 1'b1;
        else if (mode == OC_MODE_CLR) m_pin = 1'b0;
        else m_pin = ~m_pin;
      end
    end else if (match) begin
      m_pin  = 1'b1;
      m_left = PL;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_pin = 1'b0;
    end
    if (match) m_flg = 1'b1;
    else if (flg_clr) m_flg = 1'b0;
    if (wrap) m_ovf = 1'b1;
    else if (flg_clr) m_ovf = 1'b0;
    if (clr) m_cnt = '0;
    else if (cnt_en) m_cnt = m_cnt + 1'b1;
  endtask

  // One clock: queue the model's expectation, let the edge pass, compare
  task automatic tick();
    exp_t e;
    model_step();
    e.pin = m_pin; e.flg = m_flg; e.ovf = m_ovf; e.cnt = m_cnt;
    if (sb_on) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_on) begin
      e = sb_q.pop_front();
      check("sb_pin", 32'(oc_pin), 32'(e.pin));
      check("sb_flg", 32'(oc_flg), 32'(e.flg));
      check("sb_ovf", 32'(ovf_flg), 32'(e.ovf));
      check("sb_cnt", 32'(cnt_data), 32'(e.cnt));
      $display("t=%0t cnt=%0h pin=%0b flg=%0b ovf=%0b", $time, cnt_data, oc_pin, oc_flg, ovf_flg);
    end
  endtask

  // Write a compare value, then clear the counter (the clear also performs
  // the shadow transfer when preload is built in)
  task automatic load_cmp(input logic [CW-1:0] val);
    cmp_we = 1'b1; cmp_data = val; tick();
    cmp_we = 1'b0;
    clr = 1'b1; tick();
    clr = 1'b0;
  endtask

  initial begin
    srst = 1'b1; cnt_en = 1'b0; clr = 1'b0; cmp_we = 1'b0;
    cmp_data = '0; mode = OC_MODE_SET; flg_clr = 1'b0;
    tick(); tick();
    check("rst_pin", 32'(oc_pin), 0);
    check("rst_flg", 32'(oc_flg), 0);
    check("rst_ovf", 32'(ovf_flg), 0);
    check("rst_cnt", 32'(cnt_data), 0);
    srst = 1'b0;

    // Set mode, compare = 5: count 5 at edge 5, pin/flag at edge 6
    load_cmp(16'd5);
    cnt_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) begin
        check("set_cnt5", 32'(cnt_data), 5);
        check("set_pin_before", 32'(oc_pin), 0);
      end
      if (i == 6) begin
        check("set_pin", 32'(oc_pin), 1);
        check("set_flg", 32'(oc_flg), 1);
      end
    end

    // Flag clear alone, then flag clear coinciding with a match
    flg_clr = 1'b1; tick(); flg_clr = 1'b0;
    check("flgclr_alone", 32'(oc_flg), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flg_clr = 1'b1; tick();
    check("flgclr_vs_match", 32'(oc_flg), 1);
    tick(); flg_clr = 1'b0;
    check("flgclr_later", 32'(oc_flg), 0);

    // Toggle mode, compare = 3, counter parked on the compare value
    mode = OC_MODE_TGL;
    load_cmp(16'd3);
    for (int i = 0; i < 3; i++) tick();
    check("tgl_cnt3", 32'(cnt_data), 3);
    cnt_en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("stop_pin", 32'(oc_pin), 1);
    check("stop_flg", 32'(oc_flg), 0);
    cnt_en = 1'b1; tick();
    check("tgl_pin", 32'(oc_pin), 0);
    check("tgl_flg", 32'(oc_flg), 1);
    flg_clr = 1'b1; tick(); flg_clr = 1'b0;

    // Pulse mode, compare = 10, clear + compare=2 one cycle after the rise
    mode = OC_MODE_PLS;
    load_cmp(16'd10);
    for (int i = 0; i < 10; i++) tick();
    check("pls_cnt10", 32'(cnt_data), 10);
    tick();
    check("pls_rise", 32'(oc_pin), 1);
    clr = 1'b1; cmp_we = 1'b1; cmp_data = 16'd2; tick();
    clr = 1'b0; cmp_we = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("pls_retrig", 32'(oc_pin), (PRELOAD && j >= 3) ? 0 : 1);
    end

    // Reset in the middle of a pulse
    load_cmp(16'd8);
    for (int i = 0; i < 9; i++) tick();
    check("pls2_rise", 32'(oc_pin), 1);
    tick();
    srst = 1'b1; tick(); srst = 1'b0;
    check("midrst_pin", 32'(oc_pin), 0);
    check("midrst_flg", 32'(oc_flg), 0);
    check("midrst_ovf", 32'(ovf_flg), 0);
    check("midrst_cnt", 32'(cnt_data), 0);
    mode = OC_MODE_SET;
    for (int i = 0; i < 30; i++) tick();
    check("midrst_cmp_idle", 32'(oc_flg), 0);

    // Toggle across a full wrap; flag clear requested on the wrap edge
    mode = OC_MODE_TGL;
    load_cmp(16'd3);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_tgl1", 32'(oc_pin), 1);
    sb_on = 1'b0;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) tick();
    sb_on = 1'b1;
    check("wrap_reach", 32'(cnt_data), 32'hFFFE);
    check("wrap_no_ovf", 32'(ovf_flg), 0);
    tick();
    flg_clr = 1'b1; tick(); flg_clr = 1'b0;
    check("wrap_cnt0", 32'(cnt_data), 0);
    check("wrap_ovf", 32'(ovf_flg), 1);
    check("wrap_pin_hold", 32'(oc_pin), 1);
    check("wrap_flg_cleared", 32'(oc_flg), 0);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_tgl2", 32'(oc_pin), 0);
    check("wrap_flg", 32'(oc_flg), 1);
    flg_clr = 1'b1; tick(); flg_clr = 1'b0;
    check("ovf_clr", 32'(ovf_flg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_compare.md
# output_compare

Output-compare channel for the 16-bit counter design: the transmit-side counterpart of the input capture unit. A free-running counter runs off the system clock. When the counter equals a programmed compare value, the block drives a pin event (set, clear, toggle or timed pulse) and raises a sticky flag. The block sits beside the input capture unit and uses the same counter enable and clear semantics.

## Interface
- CNT_WIDTH, 16: counter and compare register width.
- PULSE_LEN, 4: pin high time in pulse mode, in clock cycles (1..255).
- i_sysclk  in  1: system clock; every register is clocked on its rising edge.
- i_sysrst  in  1: reset, synchronous, active-high.
- i_cnt_en  in  1: counter enable; the counter increments on each rising edge while high.
- i_clr  in  1: counter clear.
- i_cmp_we  in  1: compare value write strobe.
- i_cmp_data  in  CNT_WIDTH: compare value written when i_cmp_we is high.
- i_mode  in  2: match action. 00 set pin, 01 clear pin, 10 toggle pin, 11 pulse.
- i_flg_clr  in  1: clears o_oc_flg and o_ovf_flg.
- o_oc_pin  out  1: compare output pin (registered).
- o_oc_flg  out  1: sticky compare-match flag.
- o_ovf_flg  out  1: sticky counter wrap flag.
- o_cnt_data  out  CNT_WIDTH: current counter value.

## Operation
- Reset values: counter 0, active compare all-ones (0xFFFF), shadow compare all-ones, o_oc_pin 0, both flags 0, pulse timer 0.
- Counter priority: i_clr first, then i_cnt_en. If i_clr is high, the counter loads 0 regardless of i_cnt_en. Otherwise, if i_cnt_en is high, the counter increments modulo 2^CNT_WIDTH.
- Wrap: a 0xFFFF to 0 increment sets o_ovf_flg. A clear via i_clr is not a wrap.
- Match condition: counter register == active compare AND i_cnt_en == 1 in the same cycle. No event fires while the counter is stopped on the compare value, so each visit to the value produces exactly one event.
- Match actions by i_mode:
  - Set: pin goes to 1.
  - Clear: pin goes to 0.
  - Toggle: pin inverts.
  - Pulse: pin goes to 1 and the timer loads PULSE_LEN-1. The pin returns to 0 when the timer expires. A match during an active pulse reloads the timer (retrigger).
- If i_mode leaves pulse mode, the timer is zeroed and the pin holds its current level.
- Every match sets o_oc_flg.
- Same-cycle i_flg_clr and a new set event: the set wins. This applies to both flags.
- i_cmp_we without preload: the active compare register takes i_cmp_data at the next edge. A match in the same cycle uses the old value.
- Reset in mid-operation, including during a pulse: all state returns to its reset value at that edge.

## Timing
- The counter reaches value N at edge k. If i_cnt_en is high during cycle k, o_oc_pin and o_oc_flg update at edge k+1. Latency is 1 cycle.
- Pulse width on o_oc_pin is exactly PULSE_LEN cycles, measured from edge k+1 to the falling edge at edge k+1+PULSE_LEN.
- The o_ovf_flg update is visible the cycle after the wrap edge.
- o_cnt_data is the counter register itself, with no extra latency.

## Configuration
- OC_PRELOAD_EN defined:
  - i_cmp_we writes a shadow register.
  - The shadow is copied to the active compare on a counter wrap or on i_clr. This gives glitch-free period updates.
  - A write in the same cycle as a transfer updates the shadow only. The transfer uses the previous shadow value.
- OC_PRELOAD_EN undefined: there is no shadow register, and writes go straight to the active compare as described in Operation.

## Structure
- Shared package holds the following:
  - CNT_WIDTH default and the mode encodings (OC_MODE_SET=2'b00, OC_MODE_CLR=2'b01, OC_MODE_TGL=2'b10, OC_MODE_PLS=2'b11).
  - The reset compare constant (all-ones).
- One sub-module: oc_pulse_timer. It holds the PULSE_LEN down-counter and has inputs trigger, abort and reset, with output active.
- Counter, compare registers, match detect and flags stay in output_compare.

## Test plan
- Mode set, compare=5: release reset, hold i_cnt_en high. Required: o_cnt_data reaches 5 at edge 5, o_oc_pin and o_oc_flg go high at edge 6, and stay high through a counter wrap.
- Mode toggle, compare=3, run 3 wraps: o_oc_pin toggles once per wrap, and o_ovf_flg sets on the first 0xFFFF to 0 increment.
- Pulse retrigger, PULSE_LEN=4, compare=10:
  - Wait until the counter reaches 10, with o_oc_pin high in the following cycle.
  - Two cycles later, assert i_clr, and write compare=2 in the same cycle.
  - Required: without OC_PRELOAD_EN the pulse retriggers at count 2 and o_oc_pin stays high continuously. With OC_PRELOAD_EN the shadow transfer takes the old value 10, so no retrigger occurs and the pulse ends after 4 cycles.
- Stopped counter: set i_cnt_en=0 while the counter equals the compare value for 20 cycles. Required: no additional flag set, and no additional toggle in toggle mode.
- Simultaneous events: assert i_flg_clr in the same cycle a match is evaluated. Required: o_oc_flg is 1 at the next edge. i_flg_clr alone on a later cycle clears it to 0.
- Reset mid-pulse: assert i_sysrst during a pulse. Required: o_oc_pin, the flags, the counter and the timer are all 0, and compare is 0xFFFF, at the next edge.
